// File: rtl/ramf_mbank_pkg.sv
// Shared helpers for the multi-bank RAM FIFO:
// clog2, bank index width and NBANK range check.
package ramf_mbank_pkg;

  localparam int NBANK_MIN = 2;
  localparam int NBANK_MAX = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int bank_w(input int nbank);
    return (clog2(nbank) < 1) ? 1 : clog2(nbank);
  endfunction

  function automatic bit nbank_ok(input int nbank);
    return (nbank >= NBANK_MIN) && (nbank <= NBANK_MAX);
  endfunction

endpackage

// File: rtl/ramf_dp.sv
// Simple dual-port RAM: synchronous write,
// registered read address, array never reset.
module ramf_dp #(
  parameter int DW    = 12,
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr_q;
  logic [AW-1:0] raddr_d;

  // Read address is sampled every cycle.
  always_comb begin
    raddr_d = raddr;
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read address, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
    end else begin
      raddr_q <= raddr_d;
    end
  end

  assign q = mem[raddr_q];

endmodule

// File: rtl/ramf_mbank.sv
// Multi-bank ping-pong RAM FIFO: writer fills whole
// banks, reader drains them in the same rotating order.
module ramf_mbank
  import ramf_mbank_pkg::*;
#(
  parameter  int RAMD_W = 12,
  parameter  int RAMA_W = 6,
  parameter  int NBANK  = 2,
  localparam int BANK_W = bank_w(NBANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RAMA_W-1:0] wr_addr,
  input  logic [RAMD_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  output logic [BANK_W-1:0] wr_bank,
  input  logic [RAMA_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_valid,
  output logic [BANK_W-1:0] rd_bank,
  output logic [RAMD_W-1:0] q,
  output logic [BANK_W:0]   nfull,
  output logic              err
);

  localparam int AW    = BANK_W + RAMA_W;
  localparam int DEPTH = NBANK * (2 ** RAMA_W);
  localparam logic [BANK_W-1:0] LAST = BANK_W'(NBANK - 1);
  localparam logic [BANK_W:0]   NB   = (BANK_W + 1)'(NBANK);

  if (!nbank_ok(NBANK)) begin : g_bad_nbank
    $error("ramf_mbank: NBANK must be 2..4");
  end

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [BANK_W:0]   nfull_q, nfull_d;
  logic              err_q, err_d;
  logic              wr_acc, rd_acc, we;

  function automatic logic [BANK_W-1:0] bump(
    input logic [BANK_W-1:0] b
  );
    return (b == LAST) ? '0 : b + BANK_W'(1);
  endfunction

  assign wr_ready = (nfull_q < NB);
  assign rd_valid = (nfull_q != '0);
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign nfull    = nfull_q;
  assign err      = err_q;

  // Handshake acceptance, pointer advance and error capture.
  always_comb begin
    wr_acc    = wr_done & wr_ready;
    rd_acc    = rd_done & rd_valid;
    we        = wr_en & wr_ready;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    nfull_d   = nfull_q;
    err_d     = err_q;
    if (wr_acc) wr_bank_d = bump(wr_bank_q);
    if (rd_acc) rd_bank_d = bump(rd_bank_q);
    unique case ({wr_acc, rd_acc})
      2'b10:   nfull_d = nfull_q + 1'b1;
      2'b01:   nfull_d = nfull_q - 1'b1;
      default: nfull_d = nfull_q;
    endcase
    if ((wr_en | wr_done) & ~wr_ready) err_d = 1'b1;
    if (rd_done & ~rd_valid) err_d = 1'b1;
  end

  // Bank bookkeeping state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      nfull_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      nfull_q   <= nfull_d;
      err_q     <= err_d;
    end
  end

  ramf_dp #(
    .DW    (RAMD_W),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr ({wr_bank_q, wr_addr}),
    .wdata (wr_data),
    .raddr ({rd_bank_q, rd_addr}),
    .q     (q)
  );

endmodule

// File: doc/ramf_mbank.md
RAMF_MBANK -- requirements
Module: ramf_mbank

Interface
REQ-001 Parameter RAMD_W, default 12, data word width in bits.
REQ-002 Parameter RAMA_W, default 6, in-bank address width; bank depth = 2**RAMA_W words.
REQ-003 Parameter NBANK, default 2, bank count; legal range 2..4, non-power-of-2 allowed.
REQ-004 Derived BANK_W = max(1, clog2(NBANK)) bank index width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  write strobe into current write bank.
REQ-008 wr_addr  in  RAMA_W  in-bank write address.
REQ-009 wr_data  in  RAMD_W  write data.
REQ-010 wr_done  in  1  one-cycle pulse; commits current write bank as full.
REQ-011 wr_ready  out  1  a free bank is available for writing.
REQ-012 wr_bank  out  BANK_W  index of current write bank.
REQ-013 rd_addr  in  RAMA_W  in-bank read address.
REQ-014 rd_done  in  1  one-cycle pulse; releases current read bank.
REQ-015 rd_valid  out  1  a full bank is available for reading.
REQ-016 rd_bank  out  BANK_W  index of current read bank.
REQ-017 q  out  RAMD_W  read data.
REQ-018 nfull  out  BANK_W+1  number of committed, unreleased banks.
REQ-019 err  out  1  sticky: any ignored wr_en/wr_done/rd_done occurred.

Function
REQ-020 Storage SHALL be NBANK*2**RAMA_W words, addressed {bank, in-bank addr}.
REQ-021 Write: when wr_en=1 and wr_ready=1, wr_data SHALL be stored at {wr_bank, wr_addr} on the clock edge.
REQ-022 Read: {rd_bank, rd_addr} SHALL be registered every cycle; q SHALL be the word at the registered address (one-cycle latency, no read enable).
REQ-023 wr_ready SHALL equal (nfull < NBANK); rd_valid SHALL equal (nfull > 0).
REQ-024 Accepted wr_done (wr_ready=1) SHALL advance wr_bank by one, wrapping NBANK-1 -> 0, and increment nfull.
REQ-025 Accepted rd_done (rd_valid=1) SHALL advance rd_bank by one with the same wrap, and decrement nfull.
REQ-026 Both accepted in one cycle: both pointers advance, nfull unchanged.
REQ-027 wr_en or wr_done while wr_ready=0 SHALL be ignored (no write, no pointer change) and set err.
REQ-028 rd_done while rd_valid=0 SHALL be ignored and set err.
REQ-029 wr_en and wr_done in the same cycle: the write SHALL land in the bank being committed.
REQ-030 Reads with rd_valid=0 are legal; q content is unspecified.
REQ-031 A write and a read to the same physical word in one cycle cannot occur through the legal handshake; no bypass SHALL be implemented.
REQ-032 Status outputs (wr_ready, rd_valid, nfull, wr_bank, rd_bank) SHALL reflect registered state only.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear wr_bank=0, rd_bank=0, nfull=0, err=0 and the registered read address; wr_ready=1, rd_valid=0.
REQ-034 Memory contents SHALL NOT be reset; q is unspecified until the addressed word is written.
REQ-035 Reset mid-fill or mid-drain SHALL discard all bank state; data in memory is not cleared.

Structure
REQ-036 Shared package SHALL hold the clog2 function, BANK_W derivation and the NBANK legal-range check.
REQ-037 Storage SHALL be one sub-module, ramf_dp: simple dual-port RAM, synchronous write, registered read address, no reset on the array.
REQ-038 Bank pointers, nfull and err SHALL live in ramf_mbank; no other sub-modules.

Verification
REQ-039 Reset, NBANK=2: write bank 0 addr 0..63 with data=addr, wr_done -> wr_bank=1, nfull=1, rd_valid=1; read addr 5 -> q=5 one cycle later.
REQ-040 NBANK=2 fill: two wr_done with no rd_done -> nfull=2, wr_ready=0; a further wr_en at addr 0 with data 0xABC is ignored, err=1, bank 0 addr 0 still reads 0.
REQ-041 NBANK=3 wrap: 4 fill/drain cycles -> wr_bank sequence 0,1,2,0,1; rd_bank follows; read data per bank matches its tag (0x100*bank+addr).
REQ-042 Simultaneous wr_done and rd_done with nfull=1 -> nfull stays 1, both pointers advance by one.
REQ-043 rd_done with nfull=0 -> ignored, rd_bank unchanged, err=1.
REQ-044 rst_n asserted asynchronously mid-fill (nfull=1, wr_bank=1) -> immediately nfull=0, wr_bank=0, rd_bank=0, err=0, without a clock edge.
